rf_param: RTL and testbench
===========================

Name: rf_param

Overview:
Parametrised multi-read-port register file. It is the successor to the fixed 16x8, two-read-port CPU register file.
- Width, depth and read-port count are generalised.
- Read outputs are registered with same-cycle write-first forwarding.
- Adds a read stall with write-through, an optional hardwired-zero register 0, and a reset-triggered sequential clear engine.
- Sits in the CPU decode stage; writeback drives the write port.

Parameters:
DATA_WIDTH, 16, bits per register
ADDR_WIDTH, 3, select width; DEPTH = 2**ADDR_WIDTH entries
NUM_RD, 2, number of read ports (1..4)
R0_ZERO, 0, 1 = entry 0 always reads 0 and ignores writes

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
wr_en  in  1  write enable
wr_sel  in  ADDR_WIDTH  write address
wr_port  in  DATA_WIDTH  write data
rd_sel  in  NUM_RD*ADDR_WIDTH  packed read addresses; port i = bits [i*ADDR_WIDTH +: ADDR_WIDTH]
rd_stall  in  1  freeze read address capture
rd_port  out  NUM_RD*DATA_WIDTH  packed registered read data; port i = [i*DATA_WIDTH +: DATA_WIDTH]
busy  out  1  clear engine active; writes/reads not accepted

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. A posedge with rst=1 has these effects:
  - state<=CLEAR, clr_ptr<=0, busy<=1.
  - All rd_port<=0 and all latched read addresses rd_sel_q<=0.
  - Memory contents are not touched on that edge.
- States CLEAR and RUN; there is no other state.
- CLEAR, each posedge with rst=0:
  - mem[clr_ptr]<=0 and clr_ptr increments.
  - At clr_ptr==DEPTH-1: write 0, then state<=RUN and busy<=0.
  - busy is therefore high for exactly DEPTH cycles after the first rst-low edge.
  - rst reasserted mid-clear restarts at clr_ptr=0.
  - wr_en, rd_sel and rd_stall are ignored; rd_port stays 0.
- RUN, write:
  - If wr_en and not (R0_ZERO and wr_sel==0): mem[wr_sel]<=wr_port.
  - Writes are never blocked by rd_stall.
- RUN, read with rd_stall=0, per port i at posedge:
  - rd_sel_q[i]<=rd_sel[i].
  - rd_port[i]<=0 if R0_ZERO and rd_sel[i]==0.
  - Else wr_port if wr_en and wr_sel==rd_sel[i] (write-first forwarding).
  - Else mem[rd_sel[i]].
  - Read latency is 1 cycle: data for an address presented at edge N is valid after edge N.
- RUN, read with rd_stall=1:
  - rd_sel_q holds and rd_sel is ignored.
  - rd_port[i] holds, except write-through: if wr_en and wr_sel==rd_sel_q[i] and not (R0_ZERO and wr_sel==0), then rd_port[i]<=wr_port.
  - A stalled consumer thus never sees stale data.
- Multiple ports may select the same address; each gets identical data, forwarding included.
- The first edge with rd_stall=0 after a stall captures the new rd_sel normally.
- No internal combinational path from inputs to rd_port; all outputs are registered.
- busy is registered and 0 only in RUN.
- Memory is inferred as a register array or one sync-read block per read port. Forwarding must be implemented explicitly; do not rely on inferred RAM read-during-write mode.

Test Plan:
- Reset clear: preload mem with 0xFFFF via writes, pulse rst 1 cycle -> busy=1 for exactly 8 cycles (defaults), rd_port=0 throughout; afterwards reading every entry on both ports returns 0x0000.
- Write then read: write 0x1234 to r3, next cycle rd_sel port0=3 -> rd_port[15:0]=0x1234 one edge later.
- Same-cycle forwarding: wr_en=1, wr_sel=5, wr_port=0xBEEF and rd_sel port0=5, port1=5 on the same edge -> both ports 0xBEEF after that edge; mem[5]=0xBEEF on a later read.
- Stall write-through: port1 reading r2 (=0x0011), assert rd_stall, write 0x00AA to r2 and 0x0055 to r4 -> port1 becomes 0x00AA, port0 unchanged; rd_sel changes during stall are ignored until release.
- R0_ZERO=1 build: write 0xCAFE to r0, forward-read r0 -> rd_port=0 on the write edge and on all later reads.
- Reset mid-clear plus blocked writes:
  - rst at busy cycle 4 -> busy lasts 8 more cycles.
  - wr_en=1 to r1 with 0x7777 during busy -> r1 reads 0 after clear.
  - NUM_RD=4, ADDR_WIDTH=4 build passes the same checks.

Source files
------------

// File: rtl/rf_param.sv
// Parametrised register file: registered multi-port reads with write-first
// forwarding, read stall with write-through, optional hardwired r0, clear engine.
module rf_param #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_RD     = 2,
    parameter int R0_ZERO    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [ADDR_WIDTH-1:0]        wr_sel,
    input  logic [DATA_WIDTH-1:0]        wr_port,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_sel,
    input  logic                         rd_stall,
    output logic [NUM_RD*DATA_WIDTH-1:0] rd_port,
    output logic                         busy
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic R0_HARD = (R0_ZERO != 0);

    typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                            state_q, state_d;
    logic [ADDR_WIDTH-1:0]             clr_ptr_q, clr_ptr_d;
    logic                              busy_q, busy_d;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_sel_s;
    logic [NUM_RD-1:0][ADDR_WIDTH-1:0] rd_sel_q, rd_sel_d;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0] rd_port_q, rd_port_d;
    logic [DATA_WIDTH-1:0]             mem_q [DEPTH];
    logic                              mem_we_s;
    logic [ADDR_WIDTH-1:0]             mem_waddr_s;
    logic [DATA_WIDTH-1:0]             mem_wdata_s;
    logic                              wr_blocked_s;
    logic                              wr_ok_s;

    assign rd_sel_s     = rd_sel;
    assign wr_blocked_s = R0_HARD && (wr_sel == '0);
    assign wr_ok_s      = wr_en && !wr_blocked_s;

    // Next-state logic: clear sweep, architectural writes and per-port reads
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        busy_d      = busy_q;
        rd_sel_d    = rd_sel_q;
        rd_port_d   = rd_port_q;
        mem_we_s    = 1'b0;
        mem_waddr_s = wr_sel;
        mem_wdata_s = wr_port;
        case (state_q)
            ST_CLEAR: begin
                mem_we_s    = 1'b1;
                mem_waddr_s = clr_ptr_q;
                mem_wdata_s = '0;
                clr_ptr_d   = clr_ptr_q + ADDR_ONE;
                rd_port_d   = '0;
                if (clr_ptr_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end else begin
                    state_d = ST_CLEAR;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                mem_we_s = wr_ok_s;
                busy_d   = 1'b0;
                for (int i = 0; i < NUM_RD; i++) begin
                    if (!rd_stall) begin
                        rd_sel_d[i] = rd_sel_s[i];
                        // mem_q still holds the pre-write value here, so forward explicitly
                        if (R0_HARD && (rd_sel_s[i] == '0)) begin
                            rd_port_d[i] = '0;
                        end else if (wr_en && (wr_sel == rd_sel_s[i])) begin
                            rd_port_d[i] = wr_port;
                        end else begin
                            rd_port_d[i] = mem_q[rd_sel_s[i]];
                        end
                    end else if (wr_ok_s && (wr_sel == rd_sel_q[i])) begin
                        rd_port_d[i] = wr_port;
                    end else begin
                        rd_port_d[i] = rd_port_q[i];
                    end
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_ptr_d = '0;
                busy_d    = 1'b1;
                rd_sel_d  = '0;
                rd_port_d = '0;
            end
        endcase
    end

    // Control and read-output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
            rd_sel_q  <= '0;
            rd_port_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
            rd_sel_q  <= rd_sel_d;
            rd_port_q <= rd_port_d;
        end
    end

    // Storage array; contents are left untouched on a reset edge
    always_ff @(posedge clk) begin
        if (mem_we_s && !rst) begin
            mem_q[mem_waddr_s] <= mem_wdata_s;
        end
    end

    assign rd_port = rd_port_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_rf_param.sv
// Bench for rf_param: a default build (A) and a NUM_RD=4/ADDR_WIDTH=4/R0_ZERO=1
// build (B) share stimulus; a behavioural model is compared every cycle.
module tb_rf_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v, wr_en_v, stall_v;
    logic [3:0]  wsel_v;
    logic [15:0] wdata_v;
    logic [3:0]  sel_v [4];
    logic [5:0]  rd_sel_a;
    logic [15:0] rd_sel_b;
    logic [31:0] rd_port_a;
    logic [63:0] rd_port_b;
    logic        busy_a, busy_b;

    assign rd_sel_a = {sel_v[1][2:0], sel_v[0][2:0]};
    assign rd_sel_b = {sel_v[3], sel_v[2], sel_v[1], sel_v[0]};

    rf_param #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(2), .R0_ZERO(0)) dut_a (
        .clk(clk), .rst(rst_v), .wr_en(wr_en_v), .wr_sel(wsel_v[2:0]), .wr_port(wdata_v),
        .rd_sel(rd_sel_a), .rd_stall(stall_v), .rd_port(rd_port_a), .busy(busy_a));

    rf_param #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .NUM_RD(4), .R0_ZERO(1)) dut_b (
        .clk(clk), .rst(rst_v), .wr_en(wr_en_v), .wr_sel(wsel_v), .wr_port(wdata_v),
        .rd_sel(rd_sel_b), .rd_stall(stall_v), .rd_port(rd_port_b), .busy(busy_b));

    logic [15:0] m_mem [2][16];
    logic [15:0] m_rd  [2][4];
    int          m_sel [2][4];
    int          m_left [2];
    bit          m_valid;
    int          n_cmp, n_bad;
    int          ca, cb, mca, mcb;

    function automatic int dep_of(int d);
        return (d == 0) ? 8 : 16;
    endfunction

    function automatic int nrd_of(int d);
        return (d == 0) ? 2 : 4;
    endfunction

    // Advance model d by one clock edge using the currently driven inputs
    task automatic model_step(int d);
        int dep, wa, s;
        bit z, wok;
        dep = dep_of(d);
        z   = (d == 1);
        wa  = int'(wsel_v) % dep;
        if (rst_v) begin
            m_left[d] = dep;
            for (int i = 0; i < 4; i++) begin
                m_rd[d][i]  = 16'h0000;
                m_sel[d][i] = 0;
            end
        end else if (m_left[d] > 0) begin
            m_mem[d][dep - m_left[d]] = 16'h0000;
            m_left[d] = m_left[d] - 1;
        end else begin
            wok = wr_en_v && !(z && (wa == 0));
            for (int i = 0; i < nrd_of(d); i++) begin
                if (!stall_v) begin
                    s = int'(sel_v[i]) % dep;
                    m_sel[d][i] = s;
                    if (z && (s == 0)) m_rd[d][i] = 16'h0000;
                    else if (wr_en_v && (wa == s)) m_rd[d][i] = wdata_v;
                    else m_rd[d][i] = m_mem[d][s];
                end else if (wok && (wa == m_sel[d][i])) begin
                    m_rd[d][i] = wdata_v;
                end
            end
            if (wok) m_mem[d][wa] = wdata_v;
        end
    endtask

    task automatic cmp(string name, int idx, logic [15:0] got, logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    // Hand-computed literal checks on both the DUT and the model
    task automatic pin(string name, logic [15:0] got, logic [15:0] mdl, logic [15:0] exp);
        cmp({name, "_dut"}, 0, got, exp);
        cmp({name, "_model"}, 0, mdl, exp);
    endtask

    task automatic step();
        model_step(0);
        model_step(1);
        if (rst_v) m_valid = 1'b1;
        @(posedge clk);
        #1;
        if (m_valid) begin
            for (int i = 0; i < 2; i++) cmp("a_rd", i, rd_port_a[i*16 +: 16], m_rd[0][i]);
            for (int i = 0; i < 4; i++) cmp("b_rd", i, rd_port_b[i*16 +: 16], m_rd[1][i]);
            cmp("a_busy", 0, {15'h0000, busy_a}, (m_left[0] > 0) ? 16'h0001 : 16'h0000);
            cmp("b_busy", 0, {15'h0000, busy_b}, (m_left[1] > 0) ? 16'h0001 : 16'h0000);
        end
    endtask

    task automatic wait_idle(int limit);
        int n;
        n = 0;
        while ((busy_a || busy_b) && (n < limit)) begin
            step();
            n++;
        end
        n_cmp++;
        if (busy_a || busy_b) begin
            n_bad++;
            $display("FAIL wait_idle: busy a=%b b=%b after %0d cycles, required 0", busy_a, busy_b, limit);
        end
    endtask

    task automatic set_sel(int s0, int s1, int s2, int s3);
        sel_v[0] = 4'(s0);
        sel_v[1] = 4'(s1);
        sel_v[2] = 4'(s2);
        sel_v[3] = 4'(s3);
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; m_valid = 1'b0;
        m_left[0] = 0; m_left[1] = 0;
        rst_v = 1'b1; wr_en_v = 1'b0; stall_v = 1'b0; wsel_v = 4'd0; wdata_v = 16'h0000;
        set_sel(0, 0, 0, 0);
        step();
        step();
        pin("rst_busy_a", {15'h0000, busy_a}, (m_left[0] > 0) ? 16'h0001 : 16'h0000, 16'h0001);
        pin("rst_rd_a", rd_port_a[15:0], m_rd[0][0], 16'h0000);
        rst_v = 1'b0;
        wait_idle(40);

        // Preload every entry, then a one-cycle reset pulse clears the array
        wr_en_v = 1'b1; wdata_v = 16'hFFFF;
        for (int a = 0; a < 16; a++) begin
            wsel_v = 4'(a);
            step();
        end
        wr_en_v = 1'b0;
        set_sel(3, 3, 3, 3);
        step();
        pin("preload_a", rd_port_a[15:0], m_rd[0][0], 16'hFFFF);
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        ca = 0; cb = 0; mca = 0; mcb = 0;
        for (int k = 0; (k < 40) && (busy_a || busy_b); k++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (m_left[0] > 0) mca++;
            if (m_left[1] > 0) mcb++;
            step();
        end
        pin("busy_len_a", 16'(ca), 16'(mca), 16'd8);
        pin("busy_len_b", 16'(cb), 16'(mcb), 16'd16);
        for (int a = 0; a < 16; a++) begin
            set_sel(a, a, a, a);
            step();
            pin("cleared_a", rd_port_a[31:16], m_rd[0][1], 16'h0000);
            pin("cleared_b", rd_port_b[63:48], m_rd[1][3], 16'h0000);
        end

        // Write then read
        wr_en_v = 1'b1; wsel_v = 4'd3; wdata_v = 16'h1234;
        step();
        wr_en_v = 1'b0;
        set_sel(3, 0, 0, 0);
        step();
        pin("wr_rd_a", rd_port_a[15:0], m_rd[0][0], 16'h1234);
        pin("wr_rd_b", rd_port_b[15:0], m_rd[1][0], 16'h1234);

        // Same-edge forwarding to two ports
        wr_en_v = 1'b1; wsel_v = 4'd5; wdata_v = 16'hBEEF;
        set_sel(5, 5, 5, 5);
        step();
        pin("fwd_a0", rd_port_a[15:0], m_rd[0][0], 16'hBEEF);
        pin("fwd_a1", rd_port_a[31:16], m_rd[0][1], 16'hBEEF);
        wr_en_v = 1'b0;
        step();
        pin("fwd_mem_a", rd_port_a[31:16], m_rd[0][1], 16'hBEEF);

        // Stall write-through
        wr_en_v = 1'b1; wsel_v = 4'd2; wdata_v = 16'h0011;
        step();
        wr_en_v = 1'b0;
        set_sel(3, 2, 3, 2);
        step();
        pin("pre_stall_a1", rd_port_a[31:16], m_rd[0][1], 16'h0011);
        stall_v = 1'b1; wr_en_v = 1'b1; wsel_v = 4'd2; wdata_v = 16'h00AA;
        set_sel(7, 6, 7, 6);
        step();
        pin("wt_a1", rd_port_a[31:16], m_rd[0][1], 16'h00AA);
        pin("wt_a0", rd_port_a[15:0], m_rd[0][0], 16'h1234);
        wsel_v = 4'd4; wdata_v = 16'h0055;
        step();
        pin("wt_hold_a0", rd_port_a[15:0], m_rd[0][0], 16'h1234);
        pin("wt_hold_b3", rd_port_b[63:48], m_rd[1][3], 16'h00AA);
        stall_v = 1'b0; wr_en_v = 1'b0;
        step();
        pin("release_a1", rd_port_a[31:16], m_rd[0][1], 16'h0000);

        // Hardwired r0 in build B, writable r0 in build A
        wr_en_v = 1'b1; wsel_v = 4'd0; wdata_v = 16'hCAFE;
        set_sel(0, 0, 0, 0);
        step();
        pin("r0_fwd_b", rd_port_b[15:0], m_rd[1][0], 16'h0000);
        pin("r0_fwd_a", rd_port_a[15:0], m_rd[0][0], 16'hCAFE);
        wr_en_v = 1'b0;
        step();
        pin("r0_rd_b", rd_port_b[31:16], m_rd[1][1], 16'h0000);
        pin("r0_rd_a", rd_port_a[15:0], m_rd[0][0], 16'hCAFE);

        // Upper addresses of build B alias onto build A's smaller array
        wr_en_v = 1'b1; wsel_v = 4'd12; wdata_v = 16'h0C0C;
        set_sel(12, 1, 12, 3);
        step();
        pin("hi_b2", rd_port_b[47:32], m_rd[1][2], 16'h0C0C);
        pin("hi_a0", rd_port_a[15:0], m_rd[0][0], 16'h0C0C);
        wr_en_v = 1'b0;

        // Reset mid-clear restarts the sweep; writes during busy are dropped
        rst_v = 1'b1;
        step();
        rst_v = 1'b0; wr_en_v = 1'b1; wsel_v = 4'd1; wdata_v = 16'h7777;
        step(); step(); step();
        rst_v = 1'b1;
        step();
        rst_v = 1'b0;
        ca = 0; mca = 0;
        for (int k = 0; (k < 20) && busy_a; k++) begin
            ca++;
            if (m_left[0] > 0) mca++;
            step();
        end
        wr_en_v = 1'b0;
        pin("restart_len_a", 16'(ca), 16'(mca), 16'd8);
        wait_idle(40);
        set_sel(1, 1, 1, 1);
        step();
        pin("blocked_wr_a", rd_port_a[15:0], m_rd[0][0], 16'h0000);
        pin("blocked_wr_b", rd_port_b[63:48], m_rd[1][3], 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
